// File: rtl/mul_seq_ctrl.sv
// Multi-cycle RV32M multiply sequencer: shift-and-add over one shared external 32-bit adder.
// Optional macro SIGNED_MUL_EN enables signed MULH/MULHSU handling; without it all ops are unsigned.
module mul_seq_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] adder_a,
  output logic [XLEN-1:0] adder_b,
  input  logic [XLEN-1:0] adder_sum,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [2*XLEN-1:0]   r_p;
  logic [XLEN-1:0]     r_mcand;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_neg;
  logic [1:0]          r_op;
  logic [XLEN-1:0]     r_result;

  logic                w_s1;
  logic                w_s2;
  logic                w_carry;
  logic [2*XLEN-1:0]   w_fix;

  // Magnitude of an operand; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
    logic signed [XLEN-1:0] sv;
    sv = $signed(v);
    if (is_signed && (sv < 0))
      abs_val = ~v + XLEN'(1);
    else
      abs_val = v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg64(input logic [2*XLEN-1:0] v);
    neg64 = ~v + (2*XLEN)'(1);
  endfunction

`ifdef SIGNED_MUL_EN
  assign w_s1 = (r_op == OP_MULH) || (r_op == OP_MULHSU);
  assign w_s2 = (r_op == OP_MULH);
  assign w_fix = r_neg ? neg64(r_p) : r_p;
`else
  assign w_s1 = 1'b0;
  assign w_s2 = 1'b0;
  assign w_fix = r_p;
`endif

  assign w_carry = (adder_sum < adder_a);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    adder_a = '0;
    adder_b = '0;
    busy    = 1'b1;
    done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_PREP;
      end
      S_PREP: w_next = S_ITER;
      S_ITER: begin
        adder_a = r_p[2*XLEN-1:XLEN];
        adder_b = r_p[0] ? r_mcand : '0;
        if (r_cnt == CNT_W'(1)) w_next = S_FIX;
      end
      S_FIX:  w_next = S_DONE;
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: capture raw operands, fold signs in PREP, iterate, fix sign and publish result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_p      <= '0;
      r_mcand  <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_op     <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_mcand <= rs1;
            r_p     <= {{XLEN{1'b0}}, rs2};
          end
        end
        S_PREP: begin
          r_mcand <= abs_val(r_mcand, w_s1);
          r_p     <= {{XLEN{1'b0}}, abs_val(r_p[XLEN-1:0], w_s2)};
          r_neg   <= (w_s1 & r_mcand[XLEN-1]) ^ (w_s2 & r_p[XLEN-1]);
          r_cnt   <= CNT_W'(XLEN);
        end
        S_ITER: begin
          r_p   <= {w_carry, adder_sum, r_p[XLEN-1:1]};
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_FIX: begin
          r_p      <= w_fix;
          r_result <= (r_op == OP_MUL) ? w_fix[XLEN-1:0] : w_fix[2*XLEN-1:XLEN];
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: vector table, randomized ops against a 64-bit arithmetic model, abort/ignore sequences.
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1, rs2;
  logic [31:0] adder_a, adder_b, adder_sum;
  logic        busy, done;
  logic [31:0] result;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  assign adder_sum = adder_a + adder_b;

  mul_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .adder_a(adder_a), .adder_b(adder_b), .adder_sum(adder_sum),
    .busy(busy), .done(done), .result(result)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Reference: full 64-bit product from operand interpretation, then pick a word.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    sa = longint'({32'b0, a});
    sb = longint'({32'b0, b});
`ifdef SIGNED_MUL_EN
    if (o == 2'b01 || o == 2'b10) sa = longint'($signed(a));
    if (o == 2'b01)               sb = longint'($signed(b));
`endif
    p = sa * sb;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string nm, input int repulse);
    int done_at;
    int done_cnt;
    logic [31:0] res;
    bit busy_ok, adz_ok;
    done_at = 0; done_cnt = 0; res = '0; busy_ok = 1; adz_ok = 1;
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(negedge clk);
    start = 1'b0; op = ~o; rs1 = ~a; rs2 = b ^ 32'h5A5A_0F0F;
    for (int k = 1; k <= 36; k++) begin
      if (k > 1) @(negedge clk);
      if (k <= 35 && !busy) busy_ok = 0;
      if ((k == 1 || k == 34) && (adder_a != 0 || adder_b != 0)) adz_ok = 0;
      if (k <= 35 && done) begin
        done_cnt++;
        if (done_at == 0) begin done_at = k; res = result; end
      end
      if (k == 36) begin
        chk(!busy && !done, {nm, "_idle_after"}, {30'b0, busy, done}, 32'h0);
        chk(result == exp, {nm, "_held"}, result, exp);
      end
      if (repulse != 0 && k == repulse) begin
        start = 1'b1; op = 2'b00; rs1 = 32'd1234; rs2 = 32'd99;
      end else if (repulse != 0 && k == repulse + 1) begin
        start = 1'b0;
      end
    end
    chk(done_at == 35 && done_cnt == 1, {nm, "_latency"}, done_at, 32'd35);
    chk(res == exp, {nm, "_result"}, res, exp);
    chk(busy_ok, {nm, "_busy"}, {31'b0, busy_ok}, 32'h1);
    chk(adz_ok, {nm, "_adder_idle"}, {31'b0, adz_ok}, 32'h1);
  endtask

  initial begin
    logic [31:0] ra, rb, specials[4];
    logic [1:0]  ro;
    int          seen;
    specials[0] = 32'h8000_0000; specials[1] = 32'hFFFF_FFFF;
    specials[2] = 32'h0;         specials[3] = 32'h7FFF_FFFF;

    tbl[0] = '{2'b00, 32'd7,         32'd6,         32'h0000_002A};
    tbl[1] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[2] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    tbl[3] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    tbl[4] = '{2'b00, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE};
    tbl[5] = '{2'b11, 32'h8000_0000, 32'd2,         32'h0000_0001};
    tbl[6] = '{2'b00, 32'd0,         32'hDEAD_BEEF, 32'h0};
`ifdef SIGNED_MUL_EN
    tbl[7] = '{2'b01, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF};
    tbl[8] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[9] = '{2'b01, 32'h8000_0000, 32'd1,         32'hFFFF_FFFF};
`else
    tbl[7] = '{2'b01, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001};
    tbl[8] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[9] = '{2'b01, 32'h8000_0000, 32'd1,         32'h0};
`endif

    reset = 1'b1; start = 1'b0; op = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk(!busy && !done, "reset_ctrl", {30'b0, busy, done}, 32'h0);
    chk(result == 0, "reset_result", result, 32'h0);
    chk(adder_a == 0 && adder_b == 0, "reset_adder", adder_a | adder_b, 32'h0);

    for (int i = 0; i < 10; i++)
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("vec%0d", i), 0);

    // start re-pulsed mid-operation must be ignored
    run_op(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, model(2'b11, 32'h1234_5678, 32'h9ABC_DEF0), "repulse", 10);

    // reset during ITER aborts with no done pulse
    @(negedge clk);
    start = 1'b1; op = 2'b00; rs1 = 32'd9; rs2 = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk(!busy && !done, "abort_ctrl", {30'b0, busy, done}, 32'h0);
    chk(result == 0, "abort_result", result, 32'h0);
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk(seen == 0, "abort_no_done", seen, 32'h0);
    run_op(2'b00, 32'd3, 32'd5, 32'h0000_000F, "after_abort", 0);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      run_op(ro, ra, rb, model(ro, ra, rb), $sformatf("rnd%0d", i), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
